fila_andar_a: RTL and testbench
===============================

FILA_ANDAR_A -- requirements
Module: fila_andar_a

Interface
REQ-001 SHALL declare parameter CAP_FILA, default 7, maximum waiting passengers held at floor A.
REQ-002 SHALL declare parameter CAP_ELEV, default 2, passengers admitted per door-open window.
REQ-003 SHALL have port clk_2, input, 1, the single clock; all logic on its rising edge; the elevator controller runs in this same domain.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port chegada, input, 1, raw level from the arrival button; each rising edge means one new passenger.
REQ-006 SHALL have port porta, input, 1, elevator door-open status (1 = open).
REQ-007 SHALL have port andar, input, 1, elevator floor (0 = A, 1 = B).
REQ-008 SHALL have port pessoa, output, 1, registered entry strobe to the elevator; each cycle high equals one boarding.
REQ-009 SHALL have port fila, output, 3, number of passengers currently waiting.
REQ-010 SHALL have port cheia, output, 1, high when fila == CAP_FILA.
REQ-011 SHALL have port perdeu, output, 1, sticky flag: an arrival was dropped because the queue was full.

Function
REQ-012 SHALL detect an arrival as chegada=1 and chegada_r=0, where chegada_r is chegada delayed by one cycle.
REQ-013 SHALL implement states ESPERA, EMBARQUE and LOTADO.
REQ-014 SHALL hold an internal counter enviados (0..CAP_ELEV) of passengers sent in the current window.
REQ-015 SHALL leave ESPERA for EMBARQUE when porta=1 and andar=0 are sampled at the same edge.
REQ-016 SHALL, in EMBARQUE with fila>0 and enviados<CAP_ELEV, set pessoa=1 at the next edge, decrement fila and increment enviados.
REQ-017 SHALL drive pessoa=0 in every other case; pessoa may stay high on consecutive cycles, one passenger per cycle.
REQ-018 SHALL go from EMBARQUE to LOTADO at the edge where enviados reaches CAP_ELEV.
REQ-019 SHALL go from EMBARQUE or LOTADO to ESPERA, clearing enviados, when porta=0 or andar=1.
REQ-020 SHALL give the REQ-019 condition priority over REQ-016: no strobe is issued at that edge.
REQ-021 SHALL increment fila on an arrival when fila<CAP_FILA and no passenger is sent at that edge.
REQ-022 SHALL leave fila unchanged when an arrival and a send occur at the same edge.
REQ-023 SHALL leave fila unchanged on an arrival when fila==CAP_FILA and no send occurs, and set perdeu=1.
REQ-024 SHALL keep perdeu at 1 until reset.
REQ-025 SHALL accept arrivals in every state, including while the elevator is away.
REQ-026 SHALL not underflow: no strobe is issued when fila==0.
REQ-027 SHALL, if the elevator leaves with fewer than CAP_ELEV aboard (one-passenger timeout), keep the passengers not sent for the next window.

Reset
REQ-028 SHALL on reset set state=ESPERA, fila=0, enviados=0, pessoa=0, perdeu=0 and cheia=0.
REQ-029 SHALL on reset load chegada_r with chegada, so a button held through reset is not counted.
REQ-030 SHALL let reset asserted mid-operation override all other activity at that edge.

Structure
REQ-031 SHALL place the state enum (ESPERA, EMBARQUE, LOTADO) and the defaults CAP_FILA and CAP_ELEV in a shared package, elevador_pkg.
REQ-032 SHALL implement the arrival edge detector as one sub-module, detector_borda (inputs clk_2, reset, d; output pulso).
REQ-033 SHALL keep the remaining logic in fila_andar_a, with registered outputs and no latches.

Verification
REQ-034 SHALL cover: 3 arrivals with door closed, then porta=1, andar=0 -> pessoa high 2 consecutive cycles, fila 3->1, state LOTADO.
REQ-035 SHALL cover: fila=1 with door open -> one strobe; porta=0 after 3 cycles -> state ESPERA, fila=0, enviados=0.
REQ-036 SHALL cover: 8 arrivals with door closed -> fila=7, cheia=1, perdeu=1; perdeu stays 1 through a later window.
REQ-037 SHALL cover: arrival at the same edge as a strobe with fila=2 -> fila stays 2 after that edge.
REQ-038 SHALL cover: porta falls at the same edge a strobe would fire -> pessoa stays 0 and fila unchanged.
REQ-039 SHALL cover: reset pulsed during EMBARQUE with chegada held at 1 -> all outputs 0, and no arrival counted after release.

Source files
------------

// File: rtl/elevador_pkg.sv
// Shared definitions for the floor-A passenger queue: boarding FSM states
// and the default capacities of the waiting queue and of one door window.
package elevador_pkg;

    localparam int CAP_FILA_DEF = 7;
    localparam int CAP_ELEV_DEF = 2;

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        EMBARQUE = 2'd1,
        LOTADO   = 2'd2
    } estado_t;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector for the arrival button. During reset the delayed copy
// tracks the input, so a button already held when reset releases is not seen
// as a new edge.
module detector_borda (
    input  logic clk_2,
    input  logic reset,
    input  logic d,
    output logic pulso
);

    logic d_r;

    // Delay the raw level by one cycle; reset loads the current level.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            d_r <= d;
        end else begin
            d_r <= d;
        end
    end

    assign pulso = d & ~d_r;

endmodule

// File: rtl/fila_andar_a.sv
// Floor-A passenger queue. Counts arrivals, and while the elevator sits at
// floor A with its door open it sends up to CAP_ELEV passengers, one per cycle.
//
// Handshake: pessoa is a one-way strobe with no ready. Every cycle it is high
// the elevator has accepted exactly one passenger, and fila has already been
// decremented for it (unless an arrival landed on the same edge).
//
// estado and enviados are debug outputs for observing the boarding FSM.
module fila_andar_a
    import elevador_pkg::*;
#(
    parameter int CAP_FILA = CAP_FILA_DEF,
    parameter int CAP_ELEV = CAP_ELEV_DEF,
    localparam int EW = $clog2(CAP_ELEV + 1)
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          chegada,
    input  logic          porta,
    input  logic          andar,
    output logic          pessoa,
    output logic [2:0]    fila,
    output logic          cheia,
    output logic          perdeu,
    output estado_t       estado,
    output logic [EW-1:0] enviados
);

    localparam logic [2:0]    CAP_FILA_V = 3'(CAP_FILA);
    localparam logic [EW-1:0] CAP_ELEV_V = EW'(CAP_ELEV);

    logic          chegou;
    logic          sai;
    logic          envia;
    estado_t       estado_nxt;
    logic [EW-1:0] enviados_nxt;
    logic [2:0]    fila_nxt;
    logic          perdeu_nxt;

    detector_borda u_detector (
        .clk_2 (clk_2),
        .reset (reset),
        .d     (chegada),
        .pulso (chegou)
    );

    // The window closes whenever the door shuts or the car is at floor B.
    assign sai = ~porta | andar;

    // Boarding FSM, send decision and queue bookkeeping for the next edge.
    always_comb begin
        estado_nxt   = estado;
        enviados_nxt = enviados;
        envia        = 1'b0;
        case (estado)
            ESPERA: begin
                if (porta && !andar) begin
                    estado_nxt = EMBARQUE;
                end
            end
            EMBARQUE: begin
                // Closing the window wins over a pending send.
                if (sai) begin
                    estado_nxt   = ESPERA;
                    enviados_nxt = '0;
                end else if (fila != 3'd0 && enviados < CAP_ELEV_V) begin
                    envia        = 1'b1;
                    enviados_nxt = enviados + 1'b1;
                    if (enviados_nxt == CAP_ELEV_V) begin
                        estado_nxt = LOTADO;
                    end
                end
            end
            LOTADO: begin
                if (sai) begin
                    estado_nxt   = ESPERA;
                    enviados_nxt = '0;
                end
            end
            default: begin
                estado_nxt   = ESPERA;
                enviados_nxt = '0;
            end
        endcase

        // Arrival and send on the same edge cancel out.
        fila_nxt   = fila;
        perdeu_nxt = perdeu;
        if (envia && !chegou) begin
            fila_nxt = fila - 1'b1;
        end else if (chegou && !envia) begin
            if (fila < CAP_FILA_V) begin
                fila_nxt = fila + 1'b1;
            end else begin
                perdeu_nxt = 1'b1;
            end
        end
    end

    // Register state, counters and all outputs; reset overrides everything.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            estado   <= ESPERA;
            enviados <= '0;
            fila     <= 3'd0;
            pessoa   <= 1'b0;
            perdeu   <= 1'b0;
            cheia    <= 1'b0;
        end else begin
            estado   <= estado_nxt;
            enviados <= enviados_nxt;
            fila     <= fila_nxt;
            pessoa   <= envia;
            perdeu   <= perdeu_nxt;
            cheia    <= (fila_nxt == CAP_FILA_V);
        end
    end

endmodule

// File: tb/tb_fila_andar_a.sv
// Directed bench for the floor-A passenger queue.
module tb_fila_andar_a;
    import elevador_pkg::*;

    logic       clk_2;
    logic       reset;
    logic       chegada;
    logic       porta;
    logic       andar;
    logic       pessoa;
    logic [2:0] fila;
    logic       cheia;
    logic       perdeu;
    estado_t    estado;
    logic [1:0] enviados;

    int checks = 0;
    int errors = 0;

    fila_andar_a #(.CAP_FILA(7), .CAP_ELEV(2)) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .chegada  (chegada),
        .porta    (porta),
        .andar    (andar),
        .pessoa   (pessoa),
        .fila     (fila),
        .cheia    (cheia),
        .perdeu   (perdeu),
        .estado   (estado),
        .enviados (enviados)
    );

    // Clock
    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic do_reset(input logic ch);
        reset   = 1'b1;
        chegada = ch;
        porta   = 1'b0;
        andar   = 1'b0;
        tick();
        reset   = 1'b0;
    endtask

    // One button press: high for one cycle then low for one cycle.
    task automatic press();
        chegada = 1'b1;
        tick();
        chegada = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++;
        if ({pessoa, fila, cheia, perdeu} !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000", {pessoa, fila, cheia, perdeu});
        end
        checks++;
        if (estado !== ESPERA || enviados !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d/%0d want 0/0", estado, enviados);
        end
    endtask

    task automatic test_boarding();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) press();
        checks++;
        if (fila !== 3'd3) begin
            errors++; $display("FAIL board_fila3 got %0d want 3", fila);
        end
        porta = 1'b1;
        tick();
        checks++;
        if (estado !== EMBARQUE || pessoa !== 1'b0) begin
            errors++; $display("FAIL board_enter got %0d/%b want 1/0", estado, pessoa);
        end
        tick();
        checks++;
        if (pessoa !== 1'b1 || fila !== 3'd2) begin
            errors++; $display("FAIL board_send1 got %b/%0d want 1/2", pessoa, fila);
        end
        tick();
        checks++;
        if (pessoa !== 1'b1 || fila !== 3'd1 || estado !== LOTADO || enviados !== 2'd2) begin
            errors++;
            $display("FAIL board_send2 got %b/%0d/%0d/%0d want 1/1/2/2", pessoa, fila, estado, enviados);
        end
        tick();
        checks++;
        if (pessoa !== 1'b0 || fila !== 3'd1 || estado !== LOTADO) begin
            errors++; $display("FAIL board_hold got %b/%0d/%0d want 0/1/2", pessoa, fila, estado);
        end
        porta = 1'b0;
        tick();
        checks++;
        if (estado !== ESPERA || enviados !== 2'd0 || fila !== 3'd1) begin
            errors++; $display("FAIL board_close got %0d/%0d/%0d want 0/0/1", estado, enviados, fila);
        end
    endtask

    task automatic test_single();
        do_reset(1'b0);
        press();
        porta = 1'b1;
        tick();
        tick();
        checks++;
        if (pessoa !== 1'b1 || fila !== 3'd0 || enviados !== 2'd1 || estado !== EMBARQUE) begin
            errors++;
            $display("FAIL single_send got %b/%0d/%0d/%0d want 1/0/1/1", pessoa, fila, enviados, estado);
        end
        tick();
        checks++;
        if (pessoa !== 1'b0 || fila !== 3'd0) begin
            errors++; $display("FAIL single_underflow got %b/%0d want 0/0", pessoa, fila);
        end
        tick();
        porta = 1'b0;
        tick();
        checks++;
        if (estado !== ESPERA || fila !== 3'd0 || enviados !== 2'd0 || pessoa !== 1'b0) begin
            errors++;
            $display("FAIL single_timeout got %0d/%0d/%0d/%b want 0/0/0/0", estado, fila, enviados, pessoa);
        end
    endtask

    task automatic test_full();
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) press();
        checks++;
        if (fila !== 3'd7 || cheia !== 1'b1 || perdeu !== 1'b0) begin
            errors++; $display("FAIL full_seven got %0d/%b/%b want 7/1/0", fila, cheia, perdeu);
        end
        press();
        checks++;
        if (fila !== 3'd7 || cheia !== 1'b1 || perdeu !== 1'b1) begin
            errors++; $display("FAIL full_drop got %0d/%b/%b want 7/1/1", fila, cheia, perdeu);
        end
        porta = 1'b1;
        tick();
        tick();
        checks++;
        if (fila !== 3'd6 || cheia !== 1'b0 || perdeu !== 1'b1) begin
            errors++; $display("FAIL full_drain got %0d/%b/%b want 6/0/1", fila, cheia, perdeu);
        end
        tick();
        porta = 1'b0;
        tick();
        checks++;
        if (fila !== 3'd5 || perdeu !== 1'b1 || estado !== ESPERA) begin
            errors++; $display("FAIL full_sticky got %0d/%b/%0d want 5/1/0", fila, perdeu, estado);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        press();
        press();
        porta = 1'b1;
        tick();
        chegada = 1'b1;
        tick();
        checks++;
        if (pessoa !== 1'b1 || fila !== 3'd2) begin
            errors++; $display("FAIL b2b_cancel got %b/%0d want 1/2", pessoa, fila);
        end
        chegada = 1'b0;
        tick();
        checks++;
        if (pessoa !== 1'b1 || fila !== 3'd1 || estado !== LOTADO) begin
            errors++; $display("FAIL b2b_second got %b/%0d/%0d want 1/1/2", pessoa, fila, estado);
        end
        porta = 1'b0;
        tick();
    endtask

    task automatic test_door_priority();
        do_reset(1'b0);
        press();
        press();
        porta = 1'b1;
        tick();
        porta = 1'b0;
        tick();
        checks++;
        if (pessoa !== 1'b0 || fila !== 3'd2 || estado !== ESPERA) begin
            errors++; $display("FAIL door_prio got %b/%0d/%0d want 0/2/0", pessoa, fila, estado);
        end
    endtask

    task automatic test_floor_b();
        do_reset(1'b0);
        press();
        porta = 1'b1;
        andar = 1'b1;
        tick();
        tick();
        checks++;
        if (pessoa !== 1'b0 || fila !== 3'd1 || estado !== ESPERA) begin
            errors++; $display("FAIL floor_b got %b/%0d/%0d want 0/1/0", pessoa, fila, estado);
        end
        porta = 1'b0;
        andar = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        press();
        press();
        porta = 1'b1;
        tick();
        tick();
        checks++;
        if (pessoa !== 1'b1 || fila !== 3'd1) begin
            errors++; $display("FAIL rstmid_pre got %b/%0d want 1/1", pessoa, fila);
        end
        chegada = 1'b1;
        reset   = 1'b1;
        tick();
        checks++;
        if ({pessoa, fila, cheia, perdeu} !== 6'd0 || estado !== ESPERA || enviados !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_clear got %b/%0d/%0d want 000000/0/0", {pessoa, fila, cheia, perdeu}, estado, enviados);
        end
        reset = 1'b0;
        porta = 1'b0;
        tick();
        tick();
        checks++;
        if (fila !== 3'd0) begin
            errors++; $display("FAIL rstmid_held got %0d want 0", fila);
        end
        chegada = 1'b0;
        tick();
        press();
        checks++;
        if (fila !== 3'd1) begin
            errors++; $display("FAIL rstmid_after got %0d want 1", fila);
        end
    endtask

    initial begin
        reset   = 1'b1;
        chegada = 1'b0;
        porta   = 1'b0;
        andar   = 1'b0;
        test_reset();
        test_boarding();
        test_single();
        test_full();
        test_back_to_back();
        test_door_priority();
        test_floor_b();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
